byte_word_assembler: RTL and testbench

- Read-side partner of the instruction-fetch byte address generator.
- The generator issues PC+0..PC+3 to byte-wide memory. This block collects the 4 returned bytes in order, packs them into one 32-bit word and hands the word to decode over a valid/ready handshake.
- Sits between the byte-wide memory read port and the instruction register.

---
 rtl/byte_word_asm_pkg.sv | 7 +
 rtl/byte_word_assembler_if.sv | 18 +
 rtl/byte_lane_index.sv | 17 +
 rtl/byte_word_assembler.sv | 62 ++++++
 tb/tb_byte_word_assembler.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/byte_word_asm_pkg.sv
// byte_word_asm_pkg: shared state encoding and sizing for the byte-to-word assembler
package byte_word_asm_pkg;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/byte_word_assembler_if.sv
// byte_word_assembler_if: byte-in / word-out handshake bundle for the assembler
interface byte_word_assembler_if
  import byte_word_asm_pkg::*;
#(parameter int N = 32);
  logic [BYTE_W-1:0] i_byte;
  logic i_byte_vld;
  logic o_byte_rdy;
  logic i_flush;
  logic [N-1:0] o_word;
  logic o_word_vld;
  logic i_word_rdy;
  logic [IDX_W-1:0] o_count;
  logic o_err;
  modport master (output i_byte, i_byte_vld, i_flush, i_word_rdy,
                  input o_byte_rdy, o_word, o_word_vld, o_count, o_err);
  modport slave (input i_byte, i_byte_vld, i_flush, i_word_rdy,
                 output o_byte_rdy, o_word, o_word_vld, o_count, o_err);
endinterface

// File: rtl/byte_lane_index.sv
// byte_lane_index: 2-bit lane counter with sync clear, enable and wrap flag
module byte_lane_index
  import byte_word_asm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [IDX_W-1:0] cnt,
  output logic wrap
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + IDX_W'(1);
  assign wrap = en && (cnt == IDX_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs 4 in-order bytes into a little-endian word for decode
// Optional inter-byte timeout enabled by BYTE_WORD_ASSEMBLER_TIMEOUT_EN.
module byte_word_assembler
  import byte_word_asm_pkg::*;
#(
  parameter int N = 32,
  parameter int TIMEOUT = 15
) (
  input logic i_clk,
  input logic i_rst,
  byte_word_assembler_if.slave bus
);
  state_t state, state_nxt;
  logic acc, wrap, timeout;
  logic [IDX_W-1:0] cnt;
  logic [N-1:0] word;
  assign acc = bus.i_byte_vld && bus.o_byte_rdy && !bus.i_flush;
  byte_lane_index u_idx (
    .clk(i_clk), .rst(i_rst), .clr(bus.i_flush || timeout), .en(acc),
    .cnt(cnt), .wrap(wrap)
  );
`ifdef BYTE_WORD_ASSEMBLER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  logic [GAP_W-1:0] gap;
  logic err;
  // fires on the idle cycle that would bring the gap count up to TIMEOUT
  assign timeout = (state == COLLECT) && !acc && !bus.i_flush && (gap == GAP_W'(TIMEOUT - 1));
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      gap <= '0;
      err <= 1'b0;
    end else begin
      gap <= (state != COLLECT || acc || bus.i_flush || timeout) ? '0 : gap + GAP_W'(1);
      err <= timeout;
    end
  assign bus.o_err = err;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign timeout = 1'b0;
  assign bus.o_err = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (bus.i_flush || timeout) ? IDLE :
                (state == IDLE && acc) ? COLLECT :
                (state == COLLECT && wrap) ? HOLD :
                (state == HOLD && bus.i_word_rdy) ? IDLE : state;
  always_comb begin
    bus.o_byte_rdy = state != HOLD;
    bus.o_word_vld = state == HOLD;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) word <= '0;
    else
      for (int k = 0; k < BYTES_PER_WORD; k++)
        if (acc && cnt == IDX_W'(k)) word[BYTE_W*k +: BYTE_W] <= bus.i_byte;
  assign bus.o_word = word;
  assign bus.o_count = cnt;
endmodule

// File: tb/tb_byte_word_assembler.sv
// tb_byte_word_assembler: directed scoreboard bench for byte_word_assembler
module tb_byte_word_assembler;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  byte_word_assembler_if #(.N(32)) bus ();
  byte_word_assembler #(.N(32), .TIMEOUT(15)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bus.i_byte = b;
    bus.i_byte_vld = 1'b1;
    tick();
  endtask
  task automatic word4(input logic [31:0] w, input bit expect_out);
    for (int k = 0; k < 4; k++) begin
      chk("count_seq", bus.o_count, k);
      if (k == 3 && expect_out) q.push_back(w);
      send(w[8*k +: 8]);
    end
  endtask
  // scoreboard: every completed handshake must match the oldest expected word
  always @(negedge clk)
    if (!rst && bus.o_word_vld && bus.i_word_rdy && !bus.i_flush) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("sb_word", bus.o_word, q.pop_front());
    end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.i_byte = '0;
    bus.i_byte_vld = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_word_rdy = 1'b0;
    tick();
    chk("rst_rdy", bus.o_byte_rdy, 1);
    chk("rst_vld", bus.o_word_vld, 0);
    chk("rst_count", bus.o_count, 0);
    chk("rst_word", bus.o_word, 0);
    chk("rst_err", bus.o_err, 0);
    tick();
    rst = 1'b0;
    bus.i_word_rdy = 1'b1;
    word4(32'h12345678, 1);
    bus.i_byte_vld = 1'b0;
    chk("t1_vld", bus.o_word_vld, 1);
    chk("t1_word", bus.o_word, 32'h12345678);
    chk("t1_count_wrap", bus.o_count, 0);
    tick();
    chk("t1_vld_one_cycle", bus.o_word_vld, 0);
    bus.i_word_rdy = 1'b0;
    word4(32'h44332211, 1);
    bus.i_byte = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      chk("t2_rdy_low", bus.o_byte_rdy, 0);
      chk("t2_word_stable", bus.o_word, 32'h44332211);
      tick();
    end
    chk("t2_count_held", bus.o_count, 0);
    bus.i_word_rdy = 1'b1;
    tick();
    chk("t2_vld_drop", bus.o_word_vld, 0);
    chk("t2_rdy_back", bus.o_byte_rdy, 1);
    chk("t2_count_idle", bus.o_count, 0);
    tick();
    bus.i_byte_vld = 1'b0;
    chk("t2_next_count", bus.o_count, 1);
    chk("t2_lane0", bus.o_word[7:0], 8'hEE);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("t2_flush_count", bus.o_count, 0);
    send(8'hAA);
    send(8'hBB);
    chk("t3_count2", bus.o_count, 2);
    bus.i_byte = 8'hCC;
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    bus.i_byte_vld = 1'b0;
    chk("t3_flush_count", bus.o_count, 0);
    chk("t3_flush_vld", bus.o_word_vld, 0);
    tick();
    chk("t3_idle_count", bus.o_count, 0);
    word4(32'h04030201, 1);
    bus.i_byte_vld = 1'b0;
    chk("t3_vld", bus.o_word_vld, 1);
    chk("t3_word", bus.o_word, 32'h04030201);
    tick();
    chk("t3_vld_drop", bus.o_word_vld, 0);
    send(8'h05);
    send(8'h06);
    send(8'h07);
    bus.i_byte_vld = 1'b0;
    chk("t4_count3", bus.o_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_count", bus.o_count, 0);
    chk("t4_async_vld", bus.o_word_vld, 0);
    chk("t4_async_rdy", bus.o_byte_rdy, 1);
    chk("t4_async_word", bus.o_word, 0);
    #1 rst = 1'b0;
    tick();
    bus.i_word_rdy = 1'b0;
    word4(32'hA4A3A2A1, 0);
    bus.i_byte_vld = 1'b0;
    chk("t5_vld", bus.o_word_vld, 1);
    bus.i_flush = 1'b1;
    bus.i_word_rdy = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("t5_vld_drop", bus.o_word_vld, 0);
    chk("t5_count", bus.o_count, 0);
    chk("t5_rdy", bus.o_byte_rdy, 1);
    chk("t5_err", bus.o_err, 0);
    tick();
    chk("t5_err_after", bus.o_err, 0);
`ifdef BYTE_WORD_ASSEMBLER_TIMEOUT_EN
    send(8'h10);
    bus.i_byte_vld = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("t6_pre_count", bus.o_count, 1);
    chk("t6_pre_err", bus.o_err, 0);
    tick();
    chk("t6_err_pulse", bus.o_err, 1);
    chk("t6_count_clr", bus.o_count, 0);
    tick();
    chk("t6_err_once", bus.o_err, 0);
    send(8'h20);
    bus.i_byte_vld = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    send(8'h21);
    bus.i_byte_vld = 1'b0;
    chk("t6_late_count", bus.o_count, 2);
    chk("t6_late_err", bus.o_err, 0);
    tick();
    chk("t6_late_err2", bus.o_err, 0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    send(8'h30);
    bus.i_byte_vld = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("t6_flush_err", bus.o_err, 0);
    chk("t6_flush_count", bus.o_count, 0);
    tick();
    chk("t6_flush_err2", bus.o_err, 0);
`else
    send(8'h10);
    bus.i_byte_vld = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_no_timeout_count", bus.o_count, 1);
    chk("t6_no_err", bus.o_err, 0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
`endif
    tick();
    tick();
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
